// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage state encoding, RISC-V NOP bubble
// constant and the state-to-occupancy mapping.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  // addi x0, x0, 0 -- the canonical RV32 NOP used to fill empty slots
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    case (s)
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register. The main slot drives out_data, the skid
// slot catches the payload that arrives in the cycle downstream stalls, so
// in_ready can be a flop with no combinational dependence on out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire, out_fire;

  // Handshakes, bubble masking and occupancy derived from the current state
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = in_ready_q;
    in_fire   = in_valid && in_ready_q;
    out_fire  = out_valid && out_ready;
    out_data  = out_valid ? main_q : BUBBLE_VAL;
    occupancy = occ_of(state_q);
  end

  // Next-state and slot updates; flush overrides everything and kills both
  // slots (a head consumed in the same cycle has already left via out_fire)
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is registered from the next state, never from out_ready directly
    in_ready_d = (state_d != FULL);
  end

  // State, ready and payload registers; reset drops ready until first edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg configured as the IF/ID stage.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int          DATA_W = 96;
  localparam logic [95:0] BUBBLE = {RV_NOP, 64'h0};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] sb_q[$];

  pipe_skid_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL rst_out_data got %h want %h", out_data, BUBBLE); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early got %b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = (cyc < 8);
      in_data  = DATA_W'(cyc + 1);
      @(negedge clk);
      if (cyc < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc %0d got %b want 1", cyc, in_ready); end
      end
      if (cyc >= 1 && cyc <= 8) begin
        checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(cyc)) begin
          errors++; $display("FAIL stream_out cyc %0d got v=%b d=%h want v=1 d=%h", cyc, out_valid, out_data, DATA_W'(cyc));
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle cyc %0d got %b want 0", cyc, out_valid); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] exp;
    sb_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'hA; sb_q.push_back(96'hA);
    tick();
    in_data = 96'hB; sb_q.push_back(96'hB);
    tick();
    in_data = 96'hC;
    @(negedge clk);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL stall_occ got %0d want 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_data !== 96'hA || occupancy !== 2'd2) begin
        errors++; $display("FAIL stall_hold %0d got d=%h occ=%0d want d=a occ=2", i, out_data, occupancy);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checks++; if (out_valid !== 1'b1 || out_data !== exp) begin
          errors++; $display("FAIL stall_drain %0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp);
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %b want 0", out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'hA;
    tick();
    in_data = 96'hB;
    tick();
    flush = 1'b1; in_data = 96'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flushfull_valid got %b want 0", out_valid); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL flushfull_data got %h want %h", out_data, BUBBLE); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flushfull_occ got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flushfull_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flushfull_leak %0d got d=%h want no output", i, out_data); end
    end
    tick();
  endtask

  task automatic test_flush_outfire();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'hA;
    tick();
    flush = 1'b1; out_ready = 1'b1; in_data = 96'hD;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 96'hA) begin
      errors++; $display("FAIL flushfire_head got v=%b d=%h want v=1 d=a", out_valid, out_data);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++; $display("FAIL flushfire_after %0d got v=%b occ=%0d d=%h want v=0 occ=0", i, out_valid, occupancy, out_data);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'hA;
    tick();
    in_data = 96'hB;
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_pre_occ got %0d want 2", occupancy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== BUBBLE) begin errors++; $display("FAIL areset_data got %h want %h", out_data, BUBBLE); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL areset_occ got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got %b want 0", in_ready); end
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_rel_early got %b want 0", in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_rel_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_rel_valid got %b d=%h want 0", out_valid, out_data); end
  endtask

  task automatic test_random();
    logic              ir_snap;
    logic              ordy;
    logic [DATA_W-1:0] exp;
    sb_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = {$urandom, $urandom, $urandom};
      flush    = ($urandom_range(0, 31) == 0);
      ordy     = ($urandom_range(0, 2) != 0);
      out_ready = ~ordy;
      #1 ir_snap = in_ready;
      out_ready = ordy;
      #1;
      checks++;
      assert (in_ready === ir_snap) else begin
        errors++; $display("FAIL rand_comb_path cyc %0d got %b want %b", cyc, in_ready, ir_snap);
      end
      @(negedge clk);
      checks++; if (occupancy !== 2'(sb_q.size())) begin
        errors++; $display("FAIL rand_occ cyc %0d got %0d want %0d", cyc, occupancy, sb_q.size());
      end
      checks++; if (in_ready !== (sb_q.size() != 2)) begin
        errors++; $display("FAIL rand_in_ready cyc %0d got %b want %b", cyc, in_ready, sb_q.size() != 2);
      end
      checks++; if (out_valid !== (sb_q.size() != 0)) begin
        errors++; $display("FAIL rand_out_valid cyc %0d got %b want %b", cyc, out_valid, sb_q.size() != 0);
      end
      if (out_valid === 1'b1 && out_ready && sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        checks++; if (out_data !== exp) begin
          errors++; $display("FAIL rand_data cyc %0d got %h want %h", cyc, out_data, exp);
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready === 1'b1) sb_q.push_back(in_data);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_outfire();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 96, meaning the payload width (for example instr + pc + pc+4).
REQ-002 The block SHALL have parameter BUBBLE_VAL [DATA_W-1:0], default '0, meaning the value driven on out_data while the stage holds no valid entry.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the upstream stage presents a payload.
REQ-006 in_ready  output  1  the stage accepts a payload this cycle.
REQ-007 in_data  input  DATA_W  the upstream payload.
REQ-008 out_valid  output  1  out_data holds a valid entry.
REQ-009 out_ready  input  1  downstream accepts; 0 means stall.
REQ-010 out_data  output  DATA_W  the head payload.
REQ-011 flush  input  1  synchronous kill of all held entries (branch or exception redirect).
REQ-012 occupancy  output  2  the number of held entries, 0..2.

Function
REQ-013 An input transfer (in_fire) SHALL occur when in_valid && in_ready; an output transfer (out_fire) SHALL occur when out_valid && out_ready.
REQ-014 The block SHALL hold two storage slots: main, which drives out_data, and skid, which is a second entry.
REQ-015 The state machine SHALL have three states: EMPTY (0 entries), BUSY (main valid), and FULL (main and skid valid).
REQ-016 EMPTY: on in_fire, main <= in_data and the state SHALL go to BUSY; otherwise it SHALL stay EMPTY.
REQ-017 BUSY, in_fire with out_fire: main <= in_data and the state SHALL stay BUSY.
REQ-018 BUSY, in_fire without out_fire: skid <= in_data and the state SHALL go to FULL.
REQ-019 BUSY, out_fire without in_fire: the state SHALL go to EMPTY.
REQ-020 FULL, on out_fire: main <= skid and the state SHALL go to BUSY; no input is accepted in FULL.
REQ-021 in_ready SHALL be registered and SHALL equal (state != FULL); there SHALL be no combinational path from out_ready to in_ready.
REQ-022 out_valid SHALL equal (state != EMPTY); out_data SHALL equal main when out_valid is 1, and BUBBLE_VAL otherwise.
REQ-023 Latency SHALL be 1 cycle: a payload accepted at edge N is visible on out_data after edge N, provided the stage was EMPTY or draining.
REQ-024 Sustained throughput SHALL be 1 payload per cycle when out_ready is held at 1.
REQ-025 Ordering SHALL be strict FIFO; no payload is duplicated or dropped except by flush.
REQ-026 flush SHALL have the highest priority: the next state is EMPTY, both slots are invalidated, in_data offered in the same cycle is discarded, and in_ready is 1 on the next cycle.
REQ-027 flush together with out_fire in the same cycle SHALL count as a legal transfer of the current head to downstream; the remaining entries are still killed.
REQ-028 While out_ready is 0 and the state is FULL, main and skid SHALL be held unchanged indefinitely.
REQ-029 occupancy SHALL equal 0, 1 or 2 for EMPTY, BUSY or FULL respectively.
REQ-030 Payload registers SHALL NOT be cleared on flush; clearing is only required of the state register, and out_data masking provides the bubble.

Reset
REQ-031 Asserting rst SHALL immediately force: state EMPTY, out_valid 0, out_data BUBBLE_VAL, occupancy 0, in_ready 0.
REQ-032 in_ready SHALL rise to 1 on the first clk edge after rst deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all entries; no partial payload shall appear after release.
REQ-034 main and skid contents SHALL reset to BUBBLE_VAL.

Structure
REQ-035 The state enum (EMPTY, BUSY, FULL) and the constant RV_NOP = 32'h0000_0013 SHALL live in the shared package pipe_pkg.
REQ-036 The block SHALL be a single module with no sub-module; the IF/ID instance SHALL set BUBBLE_VAL to {RV_NOP, 64'h0}.

Verification
REQ-037 Stream: 8 payloads 1..8 back-to-back, out_ready=1 -> out_data is 1..8 on consecutive cycles after 1-cycle latency; in_ready stays 1.
REQ-038 Stall: load A, B with out_ready=0 -> occupancy=2 and in_ready=0; raise out_ready -> A then B, with no loss.
REQ-039 Flush while FULL: flush=1 with in_valid=1 and payload C -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0; C is never output.
REQ-040 Flush plus out_fire: BUSY holding A, flush=1 and out_ready=1 -> A is consumed downstream exactly once; the state is EMPTY.
REQ-041 Async reset: rst pulsed between clk edges while FULL -> outputs reach their reset values immediately; in_ready=1 one edge after release.
REQ-042 Random valid/ready traffic for 10k cycles, checked against a scoreboard -> ordering preserved, no combinational out_ready->in_ready path (checked by assertion).
